// File: rtl/alu_pwr_pkg.sv
// ---------------------------------------------------------------------------
// alu_pwr_pkg
// Shared definitions for the power-gated ALU sequencer and its output clamp.
//
// Contents:
//   pwr_state_e     - power sequencer state encoding (visible on pwr_state)
//   DEF_*           - default parameter values for the sequencer and clamp
//   max3            - helper used to size the shared state-duration counter
// ---------------------------------------------------------------------------
package alu_pwr_pkg;

    // State encodings are exported on the pwr_state port, so the numeric
    // values are part of the block's interface and must not be reordered.
    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_DRAIN   = 4'd1,
        ST_ISO     = 4'd2,
        ST_SAVE    = 4'd3,
        ST_PSW_OFF = 4'd4,
        ST_OFF     = 4'd5,
        ST_PSW_ON  = 4'd6,
        ST_RESTORE = 4'd7,
        ST_UNISO   = 4'd8,
        ST_ERR     = 4'd9
    } pwr_state_e;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_CLAMP_VAL   = 0;
    localparam int unsigned DEF_ISO_SETUP   = 2;
    localparam int unsigned DEF_RST_HOLD    = 4;
    localparam int unsigned DEF_PSW_TIMEOUT = 255;

    // Largest of three values; the sequencer shares one counter between the
    // isolation setup, reset hold and power-switch timeout phases.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/alu_pwr_clamp.sv
// ---------------------------------------------------------------------------
// alu_pwr_clamp
// Registered output clamp for a power-gated domain. While i_clamp is high the
// register loads CLAMP_VAL instead of the (possibly undefined) domain output,
// so downstream always-on logic never sees floating values.
//
// Ports:
//   i_clk    - clock
//   i_rst_n  - synchronous, active-low reset (loads CLAMP_VAL)
//   i_clamp  - 1 = drive CLAMP_VAL, 0 = pass i_data
//   i_data   - raw data from the gated domain
//   o_data   - registered, clamped data
// ---------------------------------------------------------------------------
module alu_pwr_clamp
    import alu_pwr_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLAMP_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clamp,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    // One register stage: the clamp decision is taken on the same edge that
    // captures the data, so the output is glitch-free and fully registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data <= CLAMP_VAL;
        end else if (i_clamp) begin
            r_data <= CLAMP_VAL;
        end else begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/alu_pwr_seq.sv
// ---------------------------------------------------------------------------
// alu_pwr_seq
// Power-domain sequencer and result clamp for a power-gated ALU. Walks the
// domain through drain, isolation, retention save, power-switch off/on,
// domain reset, retention restore and de-isolation.
//
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   sleep_req      - level request to power the ALU domain down
//   wake_req       - level request to power the ALU domain up
//   alu_busy       - ALU has an operation in flight (blocks isolation)
//   alu_result     - raw ALU output (undefined while unpowered)
//   psw_ack        - power-switch status, 1 = domain powered
//   psw_en         - power-switch enable
//   iso_en         - isolation enable into the gated domain
//   ret_save       - one-cycle retention save pulse
//   ret_restore    - one-cycle retention restore pulse
//   alu_rst_n      - domain reset, active-low
//   result         - registered, clamped ALU result
//   ready          - domain usable (state ON)
//   pwr_state      - current state encoding
//   seq_err        - sticky power-switch timeout flag
// ---------------------------------------------------------------------------
module alu_pwr_seq
    import alu_pwr_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLAMP_VAL   = WIDTH'(DEF_CLAMP_VAL),
    parameter int unsigned      ISO_SETUP   = DEF_ISO_SETUP,
    parameter int unsigned      RST_HOLD    = DEF_RST_HOLD,
    parameter int unsigned      PSW_TIMEOUT = DEF_PSW_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sleep_req,
    input  logic             wake_req,
    input  logic             alu_busy,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             psw_ack,
    output logic             psw_en,
    output logic             iso_en,
    output logic             ret_save,
    output logic             ret_restore,
    output logic             alu_rst_n,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic [3:0]       pwr_state,
    output logic             seq_err
);

    // The counter is at least clog2(PSW_TIMEOUT+1) wide, and widened if a
    // large ISO_SETUP or RST_HOLD would not otherwise fit.
    localparam int unsigned CNT_MAX = max3(PSW_TIMEOUT, ISO_SETUP, RST_HOLD);
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PSW_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD);

    pwr_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pswEn;
    logic             r_isoEn;
    logic             r_retSave;
    logic             r_retRestore;
    logic             r_aluRstN;
    logic             r_ready;
    logic             r_seqErr;

    pwr_state_e       w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_pswEn;
    logic             w_isoEn;
    logic             w_retSave;
    logic             w_retRestore;
    logic             w_aluRstN;
    logic             w_ready;
    logic             w_seqErr;
    logic             w_clamp;

    // Next-state logic. Requests are only honoured in ON (sleep), DRAIN
    // (wake abort, sleep has priority) and OFF (wake). Power-switch waits are
    // bounded; an unanswered switch lands in ERR, which only rst_n leaves.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_ON: begin
                if (sleep_req) w_stateNext = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wake_req && !sleep_req) w_stateNext = ST_ON;
                else if (!alu_busy)         w_stateNext = ST_ISO;
            end
            ST_ISO: begin
                if (r_cnt == ISO_LAST) w_stateNext = ST_SAVE;
            end
            ST_SAVE: begin
                w_stateNext = ST_PSW_OFF;
            end
            ST_PSW_OFF: begin
                if (!psw_ack)               w_stateNext = ST_OFF;
                else if (r_cnt == TMO_LAST) w_stateNext = ST_ERR;
            end
            ST_OFF: begin
                if (wake_req) w_stateNext = ST_PSW_ON;
            end
            ST_PSW_ON: begin
                if (psw_ack)                w_stateNext = ST_RESTORE;
                else if (r_cnt == TMO_LAST) w_stateNext = ST_ERR;
            end
            ST_RESTORE: begin
                if (r_cnt == RST_LAST) w_stateNext = ST_UNISO;
            end
            ST_UNISO: begin
                w_stateNext = ST_ON;
            end
            ST_ERR: begin
                w_stateNext = ST_ERR;
            end
            default: begin
                w_stateNext = ST_ERR;
            end
        endcase
    end

    // Cycles spent in the current state; restarts on every state entry and
    // saturates in the idle states so it never wraps.
    always_comb begin
        w_cntNext = r_cnt;
        if (w_stateNext != r_state) begin
            w_cntNext = '0;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            w_cntNext = r_cnt + 1'b1;
        end
    end

    // Output decode from the upcoming state and count, so the registered
    // outputs line up with pwr_state in the same cycle. RESTORE releases the
    // domain reset and fires the restore pulse together in its last cycle.
    always_comb begin
        w_pswEn      = 1'b1;
        w_isoEn      = 1'b1;
        w_retSave    = 1'b0;
        w_retRestore = 1'b0;
        w_aluRstN    = 1'b0;
        w_ready      = 1'b0;
        w_seqErr     = r_seqErr;
        case (w_stateNext)
            ST_ON: begin
                w_isoEn   = 1'b0;
                w_aluRstN = 1'b1;
                w_ready   = 1'b1;
            end
            ST_DRAIN: begin
                w_isoEn   = 1'b0;
                w_aluRstN = 1'b1;
            end
            ST_ISO: begin
                w_aluRstN = 1'b1;
            end
            ST_SAVE: begin
                w_aluRstN = 1'b1;
                w_retSave = 1'b1;
            end
            ST_PSW_OFF, ST_OFF: begin
                w_pswEn = 1'b0;
            end
            ST_PSW_ON: begin
                w_pswEn = 1'b1;
            end
            ST_RESTORE: begin
                if (w_cntNext == RST_LAST) begin
                    w_aluRstN    = 1'b1;
                    w_retRestore = 1'b1;
                end
            end
            ST_UNISO: begin
                w_isoEn   = 1'b0;
                w_aluRstN = 1'b1;
            end
            ST_ERR: begin
                w_pswEn  = r_pswEn;
                w_seqErr = 1'b1;
            end
            default: begin
                w_seqErr = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset leaves the domain held in reset and
    // isolated; the first edge after release brings it up in ON.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_ON;
            r_cnt        <= '0;
            r_pswEn      <= 1'b1;
            r_isoEn      <= 1'b1;
            r_retSave    <= 1'b0;
            r_retRestore <= 1'b0;
            r_aluRstN    <= 1'b0;
            r_ready      <= 1'b0;
            r_seqErr     <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            r_pswEn      <= w_pswEn;
            r_isoEn      <= w_isoEn;
            r_retSave    <= w_retSave;
            r_retRestore <= w_retRestore;
            r_aluRstN    <= w_aluRstN;
            r_ready      <= w_ready;
            r_seqErr     <= w_seqErr;
        end
    end

    // Besides isolation, the clamp also engages whenever the switch is off or
    // reports the domain unpowered, so a misbehaving switch can never leak
    // undefined ALU values onto result.
    assign w_clamp = r_isoEn | ~r_pswEn | ~psw_ack;

    alu_pwr_clamp #(
        .WIDTH     (WIDTH),
        .CLAMP_VAL (CLAMP_VAL)
    ) u_clamp (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clamp (w_clamp),
        .i_data  (alu_result),
        .o_data  (result)
    );

    assign psw_en      = r_pswEn;
    assign iso_en      = r_isoEn;
    assign ret_save    = r_retSave;
    assign ret_restore = r_retRestore;
    assign alu_rst_n   = r_aluRstN;
    assign ready       = r_ready;
    assign pwr_state   = r_state;
    assign seq_err     = r_seqErr;

endmodule

// File: doc/alu_pwr_seq.md
Name: alu_pwr_seq

Overview:
Power-domain sequencer and output clamp for a power-gated ALU of parametrised width. It is the next generation of the ALU top-level isolation mux. It replaces the static iso_en/alu_pwr_en inputs with an FSM that controls drain, isolation, retention save, the power-switch handshake, domain reset and restore. The result path is registered and clamped, and the clamp value is a parameter. It sits between the always-on control logic and the gated ALU domain.

Parameters:
WIDTH, 16, ALU operand/result width
CLAMP_VAL, 0, value driven on result while isolated (WIDTH bits)
ISO_SETUP, 2, cycles isolation is held before retention save (>=1)
RST_HOLD, 4, cycles alu_rst_n is held low after power-up (>=1)
PSW_TIMEOUT, 255, max cycles to wait for psw_ack in either direction (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
sleep_req  in  1  level; request power-down
wake_req  in  1  level; request power-up
alu_busy  in  1  ALU has an operation in flight
alu_result  in  WIDTH  raw ALU output (undefined when unpowered)
psw_ack  in  1  power-switch status, 1 = domain powered
psw_en  out  1  power-switch enable
iso_en  out  1  isolation enable into the gated domain
ret_save  out  1  one-cycle retention save pulse
ret_restore  out  1  one-cycle retention restore pulse
alu_rst_n  out  1  domain reset, active-low
result  out  WIDTH  registered, clamped result
ready  out  1  domain usable (state ON)
pwr_state  out  4  current FSM state encoding
seq_err  out  1  sticky power-switch timeout flag

Behaviour:
- All outputs are registered. Reset has priority over everything.
- Reset values: state=ON, psw_en=1, iso_en=1, alu_rst_n=0, ret_save=0, ret_restore=0, result=CLAMP_VAL, ready=0, seq_err=0.
- In the first cycle after reset release, state is ON and registered outputs update on the following edge: iso_en=0, alu_rst_n=1, ready=1.
- State encodings: ON=0, DRAIN=1, ISO=2, SAVE=3, PSW_OFF=4, OFF=5, PSW_ON=6, RESTORE=7, UNISO=8, ERR=9.
- ON: if sleep_req, go to DRAIN. wake_req is ignored.
- DRAIN: if wake_req && !sleep_req, abort back to ON with no side effects. Otherwise, if !alu_busy, go to ISO.
- ISO: iso_en=1 and ready=0. Hold ISO_SETUP cycles, then go to SAVE.
- SAVE: ret_save=1 for exactly one cycle, then go to PSW_OFF.
- PSW_OFF: psw_en=0 and alu_rst_n=0. Wait for psw_ack==0, then go to OFF. If psw_ack has not dropped after PSW_TIMEOUT cycles, go to ERR.
- OFF: if wake_req, go to PSW_ON. sleep_req is ignored.
- PSW_ON: psw_en=1. Wait for psw_ack==1, then go to RESTORE. Timeout goes to ERR.
- RESTORE: alu_rst_n stays low for RST_HOLD cycles, then goes high. ret_restore=1 for one cycle in the cycle alu_rst_n goes high, then go to UNISO.
- UNISO: iso_en=0, then go to ON. ready=1 from the first cycle in ON.
- ERR: seq_err=1, iso_en=1, ready=0. psw_en keeps its last value. Exit is by rst_n only.
- sleep_req and wake_req are ignored in every state not listed above. In DRAIN, if both are asserted, sleep wins.
- The timeout counter clears on every state entry. It is sized as clog2(PSW_TIMEOUT+1).
- result is updated each cycle: result <= iso_en ? CLAMP_VAL : alu_result. This uses the registered iso_en, so result has 1-cycle latency, and the clamp takes effect on result from the cycle after iso_en rises.
- result never passes alu_result while psw_en=0 or psw_ack=0.

Decomposition:
- Shared package alu_pwr_pkg: state enum pwr_state_e with the encodings above, and the default parameter constants.
- Sub-module alu_pwr_clamp: a parametrised registered clamp (WIDTH, CLAMP_VAL) that can be reused for other gated domains.
- The FSM and counters live in alu_pwr_seq.

Test Plan:
(Bench parameters: ISO_SETUP=2, RST_HOLD=4, PSW_TIMEOUT=8, CLAMP_VAL=16'hDEAD.)
- Reset, then idle with alu_result=16'h1234 -> ready=1, iso_en=0, psw_en=1, and result=16'h1234 one cycle after the input.
- sleep_req pulse with alu_busy high for 3 cycles -> stays in DRAIN for 3 cycles, then iso_en=1 for 2 cycles, one ret_save pulse, psw_en=0. Once psw_ack=0, state OFF and result=16'hDEAD throughout.
- From OFF, wake_req with psw_ack rising 3 cycles later -> alu_rst_n low for 4 cycles after ack, ret_restore pulse on its rising cycle, iso_en falls next cycle, then state ON and ready=1.
- sleep_req, then wake_req while still in DRAIN (alu_busy=1) -> returns to ON. iso_en, ret_save and psw_en never toggle.
- PSW_OFF with psw_ack stuck at 1 -> ERR after 8 cycles with seq_err=1 and result=16'hDEAD. Subsequent requests are ignored until rst_n is asserted.
- rst_n asserted while in PSW_ON -> next edge gives reset values. After release, state ON with psw_en=1.
